// File: rtl/spi_xfer_arbiter_pkg.sv
// Shared encodings and defaults for the two-port SPI transfer arbiter.
package spi_xfer_arbiter_pkg;

    localparam int unsigned DEF_W_DATA         = 32;
    localparam int unsigned DEF_W_CNT          = 16;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;

    localparam logic SPI_REQ_CPU = 1'b0;
    localparam logic SPI_REQ_AUX = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/spi_xfer_arbiter_if.sv
// Requester, engine and status signals of the SPI transfer arbiter.
interface spi_xfer_arbiter_if
    import spi_xfer_arbiter_pkg::*;
#(
    parameter int unsigned W_DATA = DEF_W_DATA,
    parameter int unsigned W_CNT  = DEF_W_CNT
);

    logic              req0;
    logic [W_DATA-1:0] wdata0;
    logic              gnt0;
    logic              done0;
    logic [W_DATA-1:0] rdata0;

    logic              req1;
    logic [W_DATA-1:0] wdata1;
    logic              gnt1;
    logic              done1;
    logic [W_DATA-1:0] rdata1;

    logic [W_DATA-1:0] spi_tx_data;
    logic              spi_tx_valid;
    logic [W_DATA-1:0] spi_rx_data;
    logic              spi_rx_valid;

    logic              busy;
    logic              err;
    logic [W_CNT-1:0]  xfer_count;

    modport slave (
        input  req0, wdata0, req1, wdata1, spi_rx_data, spi_rx_valid,
        output gnt0, done0, rdata0, gnt1, done1, rdata1,
        output spi_tx_data, spi_tx_valid, busy, err, xfer_count
    );

    modport master (
        output req0, wdata0, req1, wdata1, spi_rx_data, spi_rx_valid,
        input  gnt0, done0, rdata0, gnt1, done1, rdata1,
        input  spi_tx_data, spi_tx_valid, busy, err, xfer_count
    );

endinterface

// File: rtl/spi_xfer_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker; pointer names the favoured port.
module rr_arb2
    import spi_xfer_arbiter_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_ptr,
    output logic [1:0] o_gnt
);

    always_comb begin
        o_gnt    = 2'b00;
        o_gnt[0] = i_req[0] && (!i_req[1] || (i_ptr == SPI_REQ_CPU));
        o_gnt[1] = i_req[1] && (!i_req[0] || (i_ptr == SPI_REQ_AUX));
    end

endmodule

// File: rtl/spi_xfer_arbiter.sv
// Shares one SPI engine between CPU and aux requesters: grant, strobe, wait, respond.
// Optional WAIT-state timeout abort is enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_xfer_arbiter
    import spi_xfer_arbiter_pkg::*;
#(
    parameter int unsigned W_DATA         = DEF_W_DATA,
    parameter int unsigned W_CNT          = DEF_W_CNT,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    spi_xfer_arbiter_if.slave bus
);

    state_e            r_state;
    state_e            w_state_nxt;
    logic              r_win;
    logic              r_ptr;
    logic [1:0]        w_req;
    logic [1:0]        w_grant;
    logic              w_pick;
    logic              w_busy;
    logic              w_timeout;
    logic              w_err_flag;
    logic              w_wait_end;
    logic [W_DATA-1:0] r_tx_data;
    logic [W_DATA-1:0] r_rdata0;
    logic [W_DATA-1:0] r_rdata1;
    logic [W_CNT-1:0]  r_count;

    assign w_req  = {bus.req1, bus.req0};
    assign w_pick = w_grant[1];

    rr_arb2 u_rr_arb2 (
        .i_req (w_req),
        .i_ptr (r_ptr),
        .o_gnt (w_grant)
    );

    // rx_valid outside WAIT never reaches the FSM or the capture registers.
    assign w_wait_end = (r_state == ST_WAIT) && (bus.spi_rx_valid || w_timeout);

`ifdef SPI_ARB_TIMEOUT_EN
    logic [W_DATA-1:0] r_wait_cnt;
    logic              r_err_flag;

    always_ff @(posedge clk) begin
        if (rst || (r_state != ST_WAIT)) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= r_wait_cnt + W_DATA'(1);
        end
    end

    // A response on the expiry cycle suppresses the timeout.
    assign w_timeout = (r_state == ST_WAIT) && !bus.spi_rx_valid &&
                       (r_wait_cnt == W_DATA'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_flag <= 1'b0;
        end else if (w_wait_end) begin
            r_err_flag <= w_timeout;
        end
    end

    assign w_err_flag = r_err_flag;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
    assign w_timeout        = 1'b0;
    assign w_err_flag       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (|w_req) w_state_nxt = ST_ISSUE;
            ST_ISSUE: w_state_nxt = ST_WAIT;
            ST_WAIT:  if (w_wait_end) w_state_nxt = ST_RESP;
            ST_RESP:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_win     <= SPI_REQ_CPU;
            r_ptr     <= SPI_REQ_CPU;
            r_tx_data <= '0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
            r_count   <= '0;
        end else begin
            if ((r_state == ST_IDLE) && (|w_req)) begin
                r_win     <= w_pick;
                r_tx_data <= w_pick ? bus.wdata1 : bus.wdata0;
            end
            if (w_wait_end) begin
                if (r_win == SPI_REQ_AUX) begin
                    r_rdata1 <= w_timeout ? '0 : bus.spi_rx_data;
                end else begin
                    r_rdata0 <= w_timeout ? '0 : bus.spi_rx_data;
                end
            end
            if (r_state == ST_RESP) begin
                r_count <= r_count + W_CNT'(1);
                r_ptr   <= ~r_win;
            end
        end
    end

    assign w_busy = (r_state != ST_IDLE);

    always_comb begin
        bus.gnt0         = w_busy && (r_win == SPI_REQ_CPU);
        bus.gnt1         = w_busy && (r_win == SPI_REQ_AUX);
        bus.done0        = (r_state == ST_RESP) && (r_win == SPI_REQ_CPU);
        bus.done1        = (r_state == ST_RESP) && (r_win == SPI_REQ_AUX);
        bus.err          = (r_state == ST_RESP) && w_err_flag;
        bus.spi_tx_valid = (r_state == ST_ISSUE);
        bus.spi_tx_data  = r_tx_data;
        bus.rdata0       = r_rdata0;
        bus.rdata1       = r_rdata1;
        bus.busy         = w_busy;
        bus.xfer_count   = r_count;
    end

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Randomized and directed bench for spi_xfer_arbiter against a transaction-level model.
module tb_spi_xfer_arbiter;

    localparam int unsigned W_DATA = 32;
    localparam int unsigned W_CNT  = 4;
    localparam int unsigned T_CYC  = 8;
`ifdef SPI_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_xfer_arbiter_if #(.W_DATA(W_DATA), .W_CNT(W_CNT)) bus ();

    spi_xfer_arbiter #(
        .W_DATA         (W_DATA),
        .W_CNT          (W_CNT),
        .TIMEOUT_CYCLES (T_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level model: one owner at a time, timestamps for issue and response edges.
    int                en = 0;
    bit                mv = 1'b0;
    int                owner;
    bit                ptr;
    int                cnt;
    logic [W_DATA-1:0] m_rd [2];
    logic [W_DATA-1:0] m_tx;
    int                iss;
    int                rsp;
    bit                m_err;

    always @(posedge clk) begin
        en++;
        if (rst) begin
            mv = 1'b1; owner = -1; ptr = 1'b0; cnt = 0; m_rd[0] = '0; m_rd[1] = '0;
            m_tx = '0; iss = -10; rsp = -10; m_err = 1'b0;
        end else if (mv) begin
            if (owner < 0) begin
                if (bus.req0 || bus.req1) begin
                    owner = (bus.req0 && bus.req1) ? int'(ptr) : (bus.req1 ? 1 : 0);
                    m_tx  = (owner == 1) ? bus.wdata1 : bus.wdata0;
                    iss   = en;
                    rsp   = -10;
                end
            end else if (rsp >= 0) begin
                cnt   = (cnt + 1) % (1 << W_CNT);
                ptr   = (owner == 0);
                owner = -1;
            end else if (en >= iss + 2) begin
                if (bus.spi_rx_valid) begin
                    m_rd[owner] = bus.spi_rx_data; m_err = 1'b0; rsp = en;
                end else if (TO_EN && (en == iss + 1 + int'(T_CYC))) begin
                    m_rd[owner] = '0; m_err = 1'b1; rsp = en;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mv) begin
            chk("gnt0", bus.gnt0, owner == 0);
            chk("gnt1", bus.gnt1, owner == 1);
            chk("gnt_exclusive", bus.gnt0 && bus.gnt1, 1'b0);
            chk("busy", bus.busy, owner >= 0);
            chk("tx_valid", bus.spi_tx_valid, (owner >= 0) && (en == iss));
            chk("tx_data", bus.spi_tx_data, m_tx);
            chk("done0", bus.done0, (owner == 0) && (en == rsp));
            chk("done1", bus.done1, (owner == 1) && (en == rsp));
            chk("err", bus.err, (owner >= 0) && (en == rsp) && m_err);
            chk("rdata0", bus.rdata0, m_rd[0]);
            chk("rdata1", bus.rdata1, m_rd[1]);
            chk("xfer_count", bus.xfer_count, cnt);
        end
    end

    // Engine stand-in: manual strobes, or automatic replies with optional stray pulses.
    bit                auto_rsp = 1'b0;
    bit                stray_en = 1'b0;
    bit                man_v    = 1'b0;
    logic [W_DATA-1:0] man_d    = '0;
    int                pend     = 0;

    always @(negedge clk) begin
        if (!auto_rsp) begin
            bus.spi_rx_valid = man_v;
            bus.spi_rx_data  = man_d;
        end else begin
            bus.spi_rx_valid = 1'b0;
            if (bus.spi_tx_valid) begin
                pend = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(1, 5));
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) bus.spi_rx_valid = 1'b1;
            end
            if (stray_en && ($urandom_range(0, 9) == 0)) bus.spi_rx_valid = 1'b1;
            bus.spi_rx_data = $urandom;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_done(output int port);
        int n;
        n    = 0;
        port = -1;
        while ((port < 0) && (n < 100)) begin
            tick();
            n++;
            if (bus.done0) port = 0;
            else if (bus.done1) port = 1;
        end
        if (port < 0) begin
            checks++;
            errors++;
            $display("FAIL wait_done: no done pulse within 100 cycles, expected one");
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int p;
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.wdata0 = '0; bus.wdata1 = '0;
        bus.spi_rx_valid = 1'b0; bus.spi_rx_data = '0;

        // Reset state and a single port 0 transfer.
        do_reset();
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_gnt0", bus.gnt0, 1'b0);
        chk("rst_count", bus.xfer_count, 0);
        chk("rst_rdata0", bus.rdata0, 0);
        bus.req0 = 1'b1; bus.wdata0 = 32'hA5A5_0001;
        tick();
        chk("single_gnt0", bus.gnt0, 1'b1);
        chk("single_txv", bus.spi_tx_valid, 1'b1);
        chk("single_txd", bus.spi_tx_data, 32'hA5A5_0001);
        tick();
        chk("single_txv_once", bus.spi_tx_valid, 1'b0);
        tick();
        tick();
        man_v = 1'b1; man_d = 32'h0000_00C3;
        tick();
        chk("single_done0", bus.done0, 1'b1);
        chk("single_rdata0", bus.rdata0, 32'h0000_00C3);
        man_v = 1'b0; bus.req0 = 1'b0;
        tick();
        chk("single_done_pulse", bus.done0, 1'b0);
        chk("single_count", bus.xfer_count, 1);

        // Stray engine strobes in IDLE and ISSUE must be ignored.
        do_reset();
        man_v = 1'b1; man_d = 32'hDEAD_BEEF;
        tick();
        man_v = 1'b0;
        tick();
        chk("stray_idle_busy", bus.busy, 1'b0);
        chk("stray_idle_rdata1", bus.rdata1, 0);
        bus.req1 = 1'b1; bus.wdata1 = 32'h1111_2222; man_v = 1'b1; man_d = 32'hBAD1;
        tick();
        tick();
        chk("stray_issue_busy", bus.busy, 1'b1);
        chk("stray_issue_done1", bus.done1, 1'b0);
        chk("stray_issue_rdata1", bus.rdata1, 0);
        man_v = 1'b0;
        tick();
        man_v = 1'b1; man_d = 32'h77;
        tick();
        chk("stray_done1", bus.done1, 1'b1);
        chk("stray_rdata1", bus.rdata1, 32'h77);
        man_v = 1'b0; bus.req1 = 1'b0;
        tick();

        // Contention from reset: alternation and counter wrap with a 4-bit count.
        do_reset();
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        bus.wdata0 = $urandom; bus.wdata1 = $urandom;
        auto_rsp = 1'b1; stray_en = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            wait_done(p);
            if (i <= 4) chk("rr_order", 64'(p), 64'((i - 1) % 2));
            tick();
            if (i == 4) chk("count_after_4", bus.xfer_count, 4);
            if (i == 16) chk("count_wrap_16", bus.xfer_count, 0);
            if (i == 17) chk("count_wrap_17", bus.xfer_count, 1);
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        repeat (40) tick();
        auto_rsp = 1'b0; man_v = 1'b0;

        // Reset during WAIT aborts silently; port 1 is then served normally.
        bus.req0 = 1'b1;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("abort_gnt0", bus.gnt0, 1'b0);
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_done0", bus.done0, 1'b0);
        chk("abort_txd", bus.spi_tx_data, 0);
        chk("abort_rdata0", bus.rdata0, 0);
        chk("abort_rdata1", bus.rdata1, 0);
        chk("abort_count", bus.xfer_count, 0);
        rst = 1'b0; bus.req0 = 1'b0; bus.req1 = 1'b1; bus.wdata1 = 32'h0BAD_F00D;
        tick();
        chk("abort_gnt1", bus.gnt1, 1'b1);
        chk("abort_txd1", bus.spi_tx_data, 32'h0BAD_F00D);
        tick();
        man_v = 1'b1; man_d = 32'h5A;
        tick();
        chk("abort_done1", bus.done1, 1'b1);
        chk("abort_rd1", bus.rdata1, 32'h5A);
        man_v = 1'b0; bus.req1 = 1'b0;
        tick();

`ifdef SPI_ARB_TIMEOUT_EN
        // Response on the expiry cycle wins; a silent engine times out with err.
        do_reset();
        bus.req1 = 1'b1;
        tick();
        for (int k = 0; k < 8; k++) begin
            tick();
            if (k == 7) begin
                chk("to_edge_done1", bus.done1, 1'b0);
                man_v = 1'b1; man_d = 32'h1234_5678;
            end
        end
        tick();
        chk("to_edge_done1_pulse", bus.done1, 1'b1);
        chk("to_edge_err", bus.err, 1'b0);
        chk("to_edge_rdata1", bus.rdata1, 32'h1234_5678);
        man_v = 1'b0; bus.req1 = 1'b0;
        tick();
        tick();
        bus.req1 = 1'b1;
        tick();
        repeat (8) tick();
        chk("to_wait_busy", bus.busy, 1'b1);
        chk("to_wait_done1", bus.done1, 1'b0);
        tick();
        chk("to_done1", bus.done1, 1'b1);
        chk("to_err", bus.err, 1'b1);
        chk("to_rdata1", bus.rdata1, 0);
        bus.req1 = 1'b0;
        tick();
        tick();
`endif

        // Randomized traffic with stray strobes and occasional resets.
        do_reset();
        auto_rsp = 1'b1; stray_en = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 3) == 0) bus.req0 = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) bus.req1 = 1'($urandom_range(0, 1));
            bus.wdata0 = $urandom;
            bus.wdata1 = $urandom;
            tick();
        end
        rst = 1'b0; bus.req0 = 1'b0; bus.req1 = 1'b0; stray_en = 1'b0;
        repeat (40) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
